// File: rtl/min_reduce_ctrl.sv
// min_reduce_ctrl: streaming per-row signed minimum with argmin index
module min_reduce_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [LEN_W-1:0]  cfg_rows,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_index
);
  typedef enum logic [1:0] {IDLE, RUN, EMIT, FIN} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q, rows_q, row_cnt, elem_cnt, idx_q;
  logic [DATA_W-1:0] min_q;
  logic err_q, cfg_ok, last_elem, last_row, less;
  assign cfg_ok    = (cfg_len != '0) && (cfg_rows != '0);
  assign last_elem = elem_cnt == len_q - LEN_W'(1);
  assign last_row  = row_cnt == rows_q - LEN_W'(1);
  assign less      = $signed(in_data) < $signed(min_q);
  assign busy      = state != IDLE;
  assign done      = state == FIN;
  assign cfg_err   = err_q;
  assign in_ready  = state == RUN;
  assign out_valid = state == EMIT;
  assign out_data  = out_valid ? min_q : '0;
  assign out_index = out_valid ? idx_q : '0;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (cfg_ok ? RUN : FIN) : IDLE;
      RUN:     state_nx = (in_valid && last_elem) ? EMIT : RUN;
      EMIT:    state_nx = out_ready ? (last_row ? FIN : RUN) : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  // config latch, counters and running minimum; counters stop at len-1/rows-1 so they never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      rows_q   <= '0;
      row_cnt  <= '0;
      elem_cnt <= '0;
      min_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row_cnt  <= '0;
          elem_cnt <= '0;
          err_q    <= !cfg_ok;
          if (cfg_ok) begin
            len_q  <= cfg_len;
            rows_q <= cfg_rows;
          end
        end
        RUN: if (in_valid) begin
          min_q    <= (elem_cnt == '0 || less) ? in_data : min_q;
          idx_q    <= (elem_cnt == '0) ? '0 : (less ? elem_cnt : idx_q);
          elem_cnt <= last_elem ? '0 : elem_cnt + LEN_W'(1);
        end
        EMIT: if (out_ready && !last_row) row_cnt <= row_cnt + LEN_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/min_reduce_ctrl.md
MIN_REDUCE_CTRL -- requirements
Module: min_reduce_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: element width; elements are two's-complement signed.
REQ-002 Parameter LEN_W, default 16: width of the length, row-count and index fields.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 cfg_len  input  LEN_W  elements per row, i.e. the reduced-dimension size; latched on accepted start.
REQ-007 cfg_rows  input  LEN_W  rows per job; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at job end.
REQ-010 cfg_err  output  1  sticky error; high from a zero-size job until the next accepted start.
REQ-011 in_valid  input  1  upstream element valid.
REQ-012 in_ready  output  1  element accepted when in_valid && in_ready.
REQ-013 in_data  input  DATA_W  element value.
REQ-014 out_valid  output  1  row result valid.
REQ-015 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-016 out_data  output  DATA_W  row minimum.
REQ-017 out_index  output  LEN_W  position of the minimum within the row (0-based).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, EMIT and FIN.
REQ-019 IDLE: start=1 with cfg_len!=0 and cfg_rows!=0 -> latch config, clear row and element counters, set cfg_err=0, go to RUN.
REQ-020 IDLE: start=1 with cfg_len==0 or cfg_rows==0 -> set cfg_err=1, go to FIN; no element accepted, no result emitted.
REQ-021 in_ready SHALL equal 1 exactly in RUN; in_ready SHALL be 0 in IDLE, EMIT and FIN.
REQ-022 RUN, first accepted element of a row: min register <= in_data, idx register <= 0.
REQ-023 RUN, later accepted element: if in_data < min (signed compare), then min <= in_data and idx <= element count.
REQ-024 Ties SHALL keep the earliest index; a strict less-than comparison is used.
REQ-025 RUN, element accepted when element count == len-1 -> go to EMIT on the next edge, with min/idx already including that element.
REQ-026 RUN with in_valid=0: no state change; stalls of any length SHALL be tolerated.
REQ-027 EMIT: out_valid=1, out_data=min, out_index=idx, held stable until out_ready=1.
REQ-028 EMIT with out_ready=1: if row count == rows-1, go to FIN; otherwise increment row count, clear element count and return to RUN.
REQ-029 Latency: the result SHALL be valid one cycle after the last element handshake; the next row SHALL accept input one cycle after the result handshake.
REQ-030 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-031 A start received outside IDLE SHALL be ignored; the latched config SHALL NOT change mid-job.
REQ-032 Counters SHALL be LEN_W bits and SHALL never wrap; cfg_len = 2^LEN_W-1 SHALL be fully supported.
REQ-033 cfg_len==1 SHALL emit each element as the row minimum with out_index=0.
REQ-034 out_data and out_index SHALL be 0 whenever out_valid=0.

Reset
REQ-035 rst=1 at any clock edge, including mid-row or during EMIT, SHALL force IDLE, clear all counters and the min/idx registers, and drop any partial result.
REQ-036 Reset values: busy=0, done=0, cfg_err=0, in_ready=0, out_valid=0, out_data=0, out_index=0.
REQ-037 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-038 Single-row basic: len=4, rows=1, elements 5,-3,7,-3 -> out_data=-3, out_index=1, then a done pulse one cycle after the result handshake, then busy=0.
REQ-039 Multi-row with backpressure: len=3, rows=2, rows {10,2,8} and {-1,-9,0}, out_ready held low 5 cycles each -> results (2,1) then (-9,1); in_ready=0 throughout EMIT; outputs stable while stalled.
REQ-040 Boundary values: len=1, rows=3, inputs 0x80000000, 0x7FFFFFFF, 0 -> three results with identical values and out_index=0; then a row of 0x7FFFFFFF,0x80000000 with len=2 -> out_data=0x80000000, out_index=1.
REQ-041 Zero size: start with len=0 -> cfg_err=1, done pulse 1 cycle later, in_ready never high, out_valid never high; the next valid start clears cfg_err.
REQ-042 Reset mid-operation: rst asserted after 2 of 4 elements -> IDLE next edge with all outputs at reset values; a new job len=2 {4,1} -> (1,1).
REQ-043 Start ignored when busy: start pulsed in RUN with a different cfg_len -> the current job completes with the original length.
